multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/rv_ctrl_pkg.sv | 94 +++++++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_control.sv | 120 ++++++++++++
 tb/tb_multicycle_control.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state encoding,
// opcode/funct constants, ALU codes and the per-state control word decode.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALUCTR_AND = 4'b0000;
    localparam logic [3:0] ALUCTR_OR  = 4'b0001;
    localparam logic [3:0] ALUCTR_ADD = 4'b0010;
    localparam logic [3:0] ALUCTR_SUB = 4'b0110;
    localparam logic [3:0] ALUCTR_OFF = 4'b0000;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BIMM = 2'b11;

    // fetch/memwr mark the states whose strobes are qualified by mem_ready
    typedef struct packed {
        logic       fetch;
        logic       memwr;
        logic       retire;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] aluop;
        logic       alu_en;
        logic       trap;
    } ctrl_t;

    function automatic logic rtype_legal(input logic [6:0] f7, input logic [2:0] f3);
        return ((f7 == F7_BASE) && ((f3 == F3_ADD_SUB) || (f3 == F3_OR) || (f3 == F3_AND)))
            || ((f7 == F7_ALT) && (f3 == F3_ADD_SUB));
    endfunction

    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        c.alu_en = 1'b1;
        case (s)
            S_FETCH:    begin c.fetch = 1'b1; c.memread = 1'b1; c.alusrc_b = SRCB_FOUR; end
            S_DECODE:   c.alusrc_b = SRCB_BIMM;
            S_EXEC_R:   begin c.alusrc_a = 1'b1; c.alusrc_b = SRCB_RS2; c.aluop = ALUOP_FUNCT; end
            S_EXEC_I:   begin c.alusrc_a = 1'b1; c.alusrc_b = SRCB_IMM; end
            S_MEM_ADDR: begin c.alusrc_a = 1'b1; c.alusrc_b = SRCB_IMM; end
            S_MEM_RD:   begin c.memread = 1'b1; c.iord = 1'b1; end
            S_MEM_WR:   begin c.memwrite = 1'b1; c.iord = 1'b1; c.memwr = 1'b1; end
            S_WB_ALU:   begin c.regwrite = 1'b1; c.retire = 1'b1; end
            S_WB_MEM:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.retire = 1'b1; end
            S_BRANCH:   begin
                c.alusrc_a = 1'b1; c.alusrc_b = SRCB_RS2; c.aluop = ALUOP_SUB;
                c.pcwritecond = 1'b1; c.retire = 1'b1;
            end
            S_TRAP:     begin c = '0; c.trap = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: maps ALU class plus funct fields to ALUctr.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic       i_enable,
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output logic [3:0] o_aluctr
);

    // ALU operation select; forced to zero when the control unit is idle or trapped
    always_comb begin
        o_aluctr = ALUCTR_OFF;
        if (!i_enable) begin
            o_aluctr = ALUCTR_OFF;
        end else begin
            case (i_aluop)
                ALUOP_ADD:   o_aluctr = ALUCTR_ADD;
                ALUOP_SUB:   o_aluctr = ALUCTR_SUB;
                ALUOP_FUNCT: begin
                    case (i_funct3)
                        F3_ADD_SUB: o_aluctr = i_funct7_b5 ? ALUCTR_SUB : ALUCTR_ADD;
                        F3_AND:     o_aluctr = ALUCTR_AND;
                        F3_OR:      o_aluctr = ALUCTR_OR;
                        default:    o_aluctr = ALUCTR_ADD;
                    endcase
                end
                default:     o_aluctr = ALUCTR_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with memory wait timeout and sticky trap.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic [3:0]  state,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        irwrite,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrc_a,
    output logic [1:0]  alusrc_b,
    output logic [1:0]  ALUop,
    output logic [3:0]  ALUctr,
    output logic        retire,
    output logic        trap
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    state_t          r_state;
    state_t          w_next;
    ctrl_t           r_ctrl;
    logic [CW-1:0]   r_wait;
    logic            w_wait_max;
    logic            w_waiting;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_unused_bits;

    assign w_opcode      = instruction[6:0];
    assign w_funct3      = instruction[14:12];
    assign w_funct7      = instruction[31:25];
    assign w_unused_bits = ^{instruction[24:15], instruction[11:7]};
    assign w_wait_max    = (r_wait == CW'(WAIT_MAX));
    assign w_waiting     = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : (w_wait_max ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (w_opcode)
                    OP_RTYPE:  w_next = rtype_legal(w_funct7, w_funct3) ? S_EXEC_R : S_TRAP;
                    OP_ITYPE:  w_next = (w_funct3 == F3_ADD_SUB) ? S_EXEC_I : S_TRAP;
                    OP_LOAD:   w_next = S_MEM_ADDR;
                    OP_STORE:  w_next = S_MEM_ADDR;
                    OP_BRANCH: w_next = S_BRANCH;
                    default:   w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   w_next = S_WB_ALU;
            S_EXEC_I:   w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : (w_wait_max ? S_TRAP : S_MEM_RD);
            S_MEM_WR:   w_next = mem_ready ? S_FETCH  : (w_wait_max ? S_TRAP : S_MEM_WR);
            S_WB_ALU:   w_next = S_FETCH;
            S_WB_MEM:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    // State, control word (decoded one cycle early) and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
            r_ctrl  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_decode(w_next);
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting && !mem_ready) begin
                r_wait <= r_wait + CW'(1);
            end else begin
                r_wait <= r_wait;
            end
        end
    end

    alu_decoder u_alu_decoder (
        .i_enable    (r_ctrl.alu_en),
        .i_aluop     (r_ctrl.aluop),
        .i_funct3    (w_funct3),
        .i_funct7_b5 (instruction[30]),
        .o_aluctr    (ALUctr)
    );

    // Handshake strobes complete in the same cycle mem_ready arrives
    assign state       = r_state;
    assign pcwrite     = r_ctrl.fetch & mem_ready;
    assign irwrite     = r_ctrl.fetch & mem_ready;
    assign retire      = r_ctrl.retire | (r_ctrl.memwr & mem_ready);
    assign pcwritecond = r_ctrl.pcwritecond;
    assign iord        = r_ctrl.iord;
    assign memread     = r_ctrl.memread;
    assign memwrite    = r_ctrl.memwrite;
    assign memtoreg    = r_ctrl.memtoreg;
    assign regwrite    = r_ctrl.regwrite;
    assign alusrc_a    = r_ctrl.alusrc_a;
    assign alusrc_b    = r_ctrl.alusrc_b;
    assign ALUop       = r_ctrl.aluop;
    assign trap        = r_ctrl.trap;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level reference model
// pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int WAIT_MAX = 15;
    localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_EXEC_I = 4;
    localparam int ST_MEM_ADDR = 5, ST_MEM_RD = 6, ST_MEM_WR = 7, ST_WB_ALU = 8, ST_WB_MEM = 9;
    localparam int ST_BRANCH = 10, ST_TRAP = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic        mem_ready = 1'b0;
    logic [3:0]  state;
    logic        pcwrite, pcwritecond, irwrite, iord, memread, memwrite, memtoreg, regwrite;
    logic        alusrc_a, retire, trap;
    logic [1:0]  alusrc_b, ALUop;
    logic [3:0]  ALUctr;

    multicycle_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .state(state), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .irwrite(irwrite),
        .iord(iord), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .ALUop(ALUop),
        .ALUctr(ALUctr), .retire(retire), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] outs;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_cycle  = 0;

    function automatic logic [3:0] r_alu(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return ins[30] ? 4'b0110 : 4'b0010;
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    // Output vector: pcw,pcwc,irw,iord,mrd,mwr,m2r,rw,asa,asb[2],aop[2],actr[4],ret,trp
    function automatic logic [18:0] exp_out(input int st, input bit rdy, input logic [31:0] ins);
        logic pcw, pcwc, irw, io, mrd, mwr, m2r, rw, asa, ret, trp;
        logic [1:0] asb, aop;
        logic [3:0] actr;
        {pcw, pcwc, irw, io, mrd, mwr, m2r, rw, asa, ret, trp} = 11'd0;
        asb = 2'b00; aop = 2'b00; actr = 4'b0010;
        case (st)
            ST_FETCH:    begin mrd = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            ST_DECODE:   asb = 2'b11;
            ST_EXEC_R:   begin asa = 1'b1; aop = 2'b10; actr = r_alu(ins); end
            ST_EXEC_I:   begin asa = 1'b1; asb = 2'b10; end
            ST_MEM_ADDR: begin asa = 1'b1; asb = 2'b10; end
            ST_MEM_RD:   begin mrd = 1'b1; io = 1'b1; end
            ST_MEM_WR:   begin mwr = 1'b1; io = 1'b1; ret = rdy; end
            ST_WB_ALU:   begin rw = 1'b1; ret = 1'b1; end
            ST_WB_MEM:   begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
            ST_BRANCH:   begin asa = 1'b1; aop = 2'b01; actr = 4'b0110; pcwc = 1'b1; ret = 1'b1; end
            ST_TRAP:     begin trp = 1'b1; actr = 4'b0000; end
            default:     actr = 4'b0000;
        endcase
        return {pcw, pcwc, irw, io, mrd, mwr, m2r, rw, asa, asb, aop, actr, ret, trp};
    endfunction

    task automatic cyc(input int st, input bit rdy, input bit rst);
        exp_t e;
        reset     = rst;
        mem_ready = rdy;
        e.st      = st[3:0];
        e.outs    = exp_out(st, rdy, instruction);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int st, input int w, output bit trapped);
        if (w > WAIT_MAX) begin
            for (int i = 0; i <= WAIT_MAX; i++) cyc(st, 1'b0, 1'b0);
            trapped = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) cyc(st, 1'b0, 1'b0);
            cyc(st, 1'b1, 1'b0);
            trapped = 1'b0;
        end
    endtask

    task automatic trap_and_reset();
        for (int i = 0; i < 3; i++) cyc(ST_TRAP, 1'($urandom_range(0, 1)), 1'b0);
        cyc(ST_TRAP, 1'($urandom_range(0, 1)), 1'b1);
        cyc(ST_RESET, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Instruction-level reference: expands one instruction into its state walk
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm);
        bit tr;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit r_ok;
        instruction = ins;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        r_ok = (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7)) || (f7 == 7'h20 && f3 == 3'd0);
        wait_phase(ST_FETCH, wf, tr);
        if (tr) begin
            trap_and_reset();
        end else begin
            cyc(ST_DECODE, 1'($urandom_range(0, 1)), 1'b0);
            if (op == 7'b0110011 && r_ok) begin
                cyc(ST_EXEC_R, 1'($urandom_range(0, 1)), 1'b0);
                cyc(ST_WB_ALU, 1'($urandom_range(0, 1)), 1'b0);
            end else if (op == 7'b0010011 && f3 == 3'd0) begin
                cyc(ST_EXEC_I, 1'($urandom_range(0, 1)), 1'b0);
                cyc(ST_WB_ALU, 1'($urandom_range(0, 1)), 1'b0);
            end else if (op == 7'b0000011) begin
                cyc(ST_MEM_ADDR, 1'($urandom_range(0, 1)), 1'b0);
                wait_phase(ST_MEM_RD, wm, tr);
                if (tr) trap_and_reset();
                else cyc(ST_WB_MEM, 1'($urandom_range(0, 1)), 1'b0);
            end else if (op == 7'b0100011) begin
                cyc(ST_MEM_ADDR, 1'($urandom_range(0, 1)), 1'b0);
                wait_phase(ST_MEM_WR, wm, tr);
                if (tr) trap_and_reset();
            end else if (op == 7'b1100011) begin
                cyc(ST_BRANCH, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                trap_and_reset();
            end
        end
    endtask

    function automatic logic [31:0] rnd_ins(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0: return {7'h00, r[24:15], 3'd0, r[11:7], 7'b0110011};
            1: return {7'h20, r[24:15], 3'd0, r[11:7], 7'b0110011};
            2: return {7'h00, r[24:15], 3'd7, r[11:7], 7'b0110011};
            3: return {7'h00, r[24:15], 3'd6, r[11:7], 7'b0110011};
            4: return {r[31:15], 3'd0, r[11:7], 7'b0010011};
            5: return {r[31:15], 3'd2, r[11:7], 7'b0000011};
            6: return {r[31:15], 3'd2, r[11:7], 7'b0100011};
            7: return {r[31:15], 3'd0, r[11:7], 7'b1100011};
            8: return {7'h00, r[24:15], 3'd1, r[11:7], 7'b0110011};
            default: return {r[31:15], 3'd4, r[11:7], 7'b0010011};
        endcase
    endfunction

    // Monitor: compare DUT state and outputs against the next expectation
    always @(negedge clk) begin
        exp_t e;
        logic [18:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {pcwrite, pcwritecond, irwrite, iord, memread, memwrite, memtoreg, regwrite,
                   alusrc_a, alusrc_b, ALUop, ALUctr, retire, trap};
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL state @%0d: actual=%0d required=%0d", n_cycle, state, e.st);
            end
            n_checks++;
            if (act !== e.outs) begin
                n_fail++;
                $display("FAIL outputs @%0d (state %0d): actual=%b required=%b", n_cycle, e.st, act, e.outs);
            end
        end
        n_cycle++;
    end

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(ST_RESET, 1'b1, 1'b1);
        cyc(ST_RESET, 1'b1, 1'b0);
        run_instr(32'h00000033, 0, 0);
        run_instr(32'h40000033, 0, 0);
        run_instr(32'h00006033, 1, 0);
        run_instr(32'h00007033, 0, 0);
        run_instr(32'h00002003, 0, 3);
        run_instr(32'h00002023, 2, 2);
        run_instr(32'h00000063, 0, 0);
        run_instr(32'h00000013, WAIT_MAX, 0);
        run_instr(32'h00002003, 0, WAIT_MAX);
        run_instr(32'h0000007F, 0, 0);
        run_instr(32'h00000033, WAIT_MAX + 1, 0);
        run_instr(32'h00002023, 0, WAIT_MAX + 1);
        // reset asserted while MEM_RD is still waiting
        instruction = 32'h00002003;
        cyc(ST_FETCH, 1'b1, 1'b0);
        cyc(ST_DECODE, 1'b0, 1'b0);
        cyc(ST_MEM_ADDR, 1'b0, 1'b0);
        cyc(ST_MEM_RD, 1'b0, 1'b0);
        cyc(ST_MEM_RD, 1'b0, 1'b0);
        cyc(ST_MEM_RD, 1'b0, 1'b1);
        cyc(ST_RESET, 1'b1, 1'b0);
        for (int k = 0; k < 60; k++) begin
            int kind, wf, wm;
            kind = $urandom_range(0, 9);
            if (kind == 9 && $urandom_range(0, 1) == 0) kind = $urandom_range(0, 7);
            wf = ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, 3);
            run_instr(rnd_ins(kind), wf, wm);
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
